// File: rtl/lock_sequencer.sv
// Canal-lock sequencer: serves boat arrivals at either gate, moves the chamber level
// and publishes the active phase with its countdown for the 7-segment display.
//
// state | meaning
// IDLE  | no boat in service, arrivals sampled
// PREP  | bring chamber level to the boat side (dir=0 drain, dir=1 fill)
// ENTER | gate open, boat enters (waiting)
// MOVE  | carry boat to the other level (dir=0 fill, dir=1 drain)
// EXIT  | gate open, boat leaves (waiting)
module lock_sequencer #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int WAIT_SECS  = 5,
    parameter int FILL_SECS  = 8,
    parameter int DRAIN_SECS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arrive_low,
    input  logic       arrive_high,
    output logic       draining,
    output logic       filling,
    output logic       waiting,
    output logic [3:0] drainVal,
    output logic [3:0] fillVal,
    output logic [3:0] waitVal,
    output logic       level_high,
    output logic       busy
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [2:0] {IDLE, PREP, ENTER, MOVE, EXIT} state_t;

    state_t        state_q, state_d;
    logic          dir_q, dir_d;
    logic          lvl_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [3:0]    val_q, val_d;
    logic          load;
    logic          drn_d, fil_d, wt_d;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        lvl_d   = level_high;
        tick_d  = '0;
        val_d   = val_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                val_d = '0;
                if (arrive_low || arrive_high) begin
                    // Simultaneous arrivals favour the gate whose level already matches.
                    dir_d   = (arrive_low && arrive_high) ? level_high : arrive_high;
                    state_d = (dir_d == level_high) ? ENTER : PREP;
                    load    = 1'b1;
                end
            end
            default: begin
                tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
                if (tick_q == TICK_LAST) begin
                    if (val_q != 4'd0) begin
                        val_d = val_q - 4'd1;
                    end else begin
                        load = 1'b1;
                        if (filling)  lvl_d = 1'b1;
                        if (draining) lvl_d = 1'b0;
                        case (state_q)
                            PREP:    state_d = ENTER;
                            ENTER:   state_d = MOVE;
                            MOVE:    state_d = EXIT;
                            default: state_d = IDLE;
                        endcase
                    end
                end
            end
        endcase

        wt_d  = (state_d == ENTER) || (state_d == EXIT);
        fil_d = ((state_d == PREP) && dir_d) || ((state_d == MOVE) && !dir_d);
        drn_d = ((state_d == PREP) && !dir_d) || ((state_d == MOVE) && dir_d);

        if (load) begin
            if (wt_d)       val_d = 4'(WAIT_SECS);
            else if (fil_d) val_d = 4'(FILL_SECS);
            else if (drn_d) val_d = 4'(DRAIN_SECS);
            else            val_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            dir_q      <= 1'b0;
            tick_q     <= '0;
            val_q      <= '0;
            level_high <= 1'b0;
            busy       <= 1'b0;
            draining   <= 1'b0;
            filling    <= 1'b0;
            waiting    <= 1'b0;
            drainVal   <= '0;
            fillVal    <= '0;
            waitVal    <= '0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            tick_q     <= tick_d;
            val_q      <= val_d;
            level_high <= lvl_d;
            busy       <= (state_d != IDLE);
            draining   <= drn_d;
            filling    <= fil_d;
            waiting    <= wt_d;
            drainVal   <= drn_d ? val_d : 4'd0;
            fillVal    <= fil_d ? val_d : 4'd0;
            waitVal    <= wt_d  ? val_d : 4'd0;
        end
    end

endmodule
